// File: rtl/light_manager_mc.sv
// rtl/light_manager_mc.sv - encoder/button driven multi-channel PWM LED brightness manager
module light_manager_mc #(
   parameter int CLOCK_FREQ_MHZ   = 100,
   parameter int DEBOUNCE_US      = 1,
   parameter int PWM_VALUE_SIZE   = 8,
   parameter int BRIGHTNESS_INC   = 10,
   parameter int CHANNELS         = 4,
   parameter int RESET_BRIGHTNESS = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        a_i,
   input  logic                        b_i,
   input  logic                        btn_i,
   output logic [CHANNELS-1:0]         leds_o,
   output logic [$clog2(CHANNELS)-1:0] sel_o,
   output logic [PWM_VALUE_SIZE-1:0]   brightness_o
);

   localparam int W      = PWM_VALUE_SIZE;
   localparam int SEL_W  = $clog2(CHANNELS);
   localparam int N      = CLOCK_FREQ_MHZ * DEBOUNCE_US;
   localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [W-1:0]     B_MAX    = '1;
   localparam logic [W-1:0]     B_INC    = W'(BRIGHTNESS_INC);
   localparam logic [W-1:0]     B_RST    = W'(RESET_BRIGHTNESS);
   localparam logic             LED_RST  = (RESET_BRIGHTNESS > 0);

   typedef enum logic [2:0] {S_IDLE, S_R1, S_R2, S_R3, S_L1, S_L2, S_L3} state_t;

   // index 0 = A, 1 = B, 2 = button
   logic [2:0]       r_meta, r_sync, r_prev, r_deb;
   logic [CNT_W-1:0] r_cnt [3];
   logic             r_btn_prev;
   state_t           r_state, w_state_nxt;
   logic             w_inc, w_dec, w_btn_rise;
   logic [1:0]       w_ab;
   logic [W-1:0]     r_bright [CHANNELS];
   logic [SEL_W-1:0] r_sel;
   logic [W-1:0]     r_pwm_cnt;
   logic [CHANNELS-1:0] r_leds;
   logic [W-1:0]     w_cur, w_inc_val, w_dec_val;
   logic [W:0]       w_sum;

   assign w_ab       = {r_deb[0], r_deb[1]};
   assign w_btn_rise = r_deb[2] & ~r_btn_prev;
   assign w_cur      = r_bright[r_sel];
   assign w_sum      = {1'b0, w_cur} + {1'b0, B_INC};
   assign w_inc_val  = (w_sum > {1'b0, B_MAX}) ? B_MAX : w_sum[W-1:0];
   assign w_dec_val  = (w_cur < B_INC) ? '0 : (w_cur - B_INC);

   // two-flop synchronisers and per-input debounce; a changing or already-accepted input keeps the counter at zero
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_meta     <= 3'b011;
         r_sync     <= 3'b011;
         r_prev     <= 3'b011;
         r_deb      <= 3'b011;
         r_btn_prev <= 1'b0;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_meta     <= {btn_i, b_i, a_i};
         r_sync     <= r_meta;
         r_prev     <= r_sync;
         r_btn_prev <= r_deb[2];
         for (int i = 0; i < 3; i++) begin
            if (r_sync[i] == r_deb[i] || r_sync[i] != r_prev[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= r_sync[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // quadrature decoder state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // quadrature next state; inc/dec only on the last step of a full detent back to 11
   always_comb begin
      w_state_nxt = r_state;
      w_inc       = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         S_IDLE: if (w_ab == 2'b01) w_state_nxt = S_R1;
                 else if (w_ab == 2'b10) w_state_nxt = S_L1;
         S_R1:   if (w_ab == 2'b00) w_state_nxt = S_R2;
                 else if (w_ab == 2'b11) w_state_nxt = S_IDLE;
         S_R2:   if (w_ab == 2'b10) w_state_nxt = S_R3;
                 else if (w_ab == 2'b01) w_state_nxt = S_R1;
         S_R3:   if (w_ab == 2'b11) begin w_state_nxt = S_IDLE; w_inc = 1'b1; end
                 else if (w_ab == 2'b00) w_state_nxt = S_R2;
         S_L1:   if (w_ab == 2'b00) w_state_nxt = S_L2;
                 else if (w_ab == 2'b11) w_state_nxt = S_IDLE;
         S_L2:   if (w_ab == 2'b01) w_state_nxt = S_L3;
                 else if (w_ab == 2'b10) w_state_nxt = S_L1;
         S_L3:   if (w_ab == 2'b11) begin w_state_nxt = S_IDLE; w_dec = 1'b1; end
                 else if (w_ab == 2'b00) w_state_nxt = S_L2;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // brightness of the current selection and selection advance; both use the pre-edge selection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sel <= '0;
         for (int k = 0; k < CHANNELS; k++) r_bright[k] <= B_RST;
      end else begin
         if (w_inc)      r_bright[r_sel] <= w_inc_val;
         else if (w_dec) r_bright[r_sel] <= w_dec_val;
         if (w_btn_rise) r_sel <= (r_sel == SEL_W'(CHANNELS - 1)) ? '0 : r_sel + 1'b1;
      end
   end

   // shared PWM counter over 0..2^W-2 so that full-scale brightness is a constant high
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pwm_cnt <= '0;
         r_leds    <= {CHANNELS{LED_RST}};
      end else begin
         r_pwm_cnt <= (r_pwm_cnt == B_MAX - 1'b1) ? '0 : r_pwm_cnt + 1'b1;
         for (int k = 0; k < CHANNELS; k++) r_leds[k] <= (r_pwm_cnt < r_bright[k]);
      end
   end

   assign leds_o       = r_leds;
   assign sel_o        = r_sel;
   assign brightness_o = w_cur;

endmodule

// File: tb/tb_light_manager_mc.sv
// tb/tb_light_manager_mc.sv - directed self-checking bench for light_manager_mc
`timescale 1ns/1ps
module tb_light_manager_mc;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       a_i   = 1'b1;
   logic       b_i   = 1'b1;
   logic       btn_i = 1'b0;
   logic [3:0] leds_o;
   logic [1:0] sel_o;
   logic [7:0] brightness_o;

   int n_checks = 0;
   int n_err    = 0;
   int hi;
   int exp_b;

   localparam int PH = 150;

   light_manager_mc dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .a_i          (a_i),
      .b_i          (b_i),
      .btn_i        (btn_i),
      .leds_o       (leds_o),
      .sel_o        (sel_o),
      .brightness_o (brightness_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wcyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic detent_r();
      a_i = 1'b0; wcyc(PH);
      b_i = 1'b0; wcyc(PH);
      a_i = 1'b1; wcyc(PH);
      b_i = 1'b1; wcyc(PH);
   endtask

   task automatic detent_l();
      b_i = 1'b0; wcyc(PH);
      a_i = 1'b0; wcyc(PH);
      b_i = 1'b1; wcyc(PH);
      a_i = 1'b1; wcyc(PH);
   endtask

   task automatic press();
      btn_i = 1'b1; wcyc(PH);
      btn_i = 1'b0; wcyc(PH);
   endtask

   // which: 0 = A, 1 = B; 100 cycles of random bounce ending on the target level
   task automatic chatter(input int which, input logic target);
      for (int i = 0; i < 100; i++) begin
         if (which == 0) a_i = 1'($urandom_range(0, 1));
         else            b_i = 1'($urandom_range(0, 1));
         wcyc(1);
      end
      if (which == 0) a_i = target;
      else            b_i = target;
   endtask

   task automatic count_led(input int ch, output int cnt);
      cnt = 0;
      repeat (255) begin
         @(negedge clk_i);
         cnt += int'(leds_o[ch]);
      end
   endtask

   initial begin
      // reset and idle
      wcyc(3);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_val("rst_leds", 32'(leds_o), 0);
      check_val("rst_sel", 32'(sel_o), 0);
      check_val("rst_bright", 32'(brightness_o), 0);
      wcyc(1000);
      check_val("idle_bright", 32'(brightness_o), 0);
      check_val("idle_leds", 32'(leds_o), 0);

      // right detent with bounce on every edge
      a_i = 1'b0; chatter(0, 1'b0); wcyc(200);
      b_i = 1'b0; chatter(1, 1'b0); wcyc(400);
      a_i = 1'b1; chatter(0, 1'b1); wcyc(200);
      check_val("det_pre", 32'(brightness_o), 0);
      b_i = 1'b1; chatter(1, 1'b1); wcyc(300);
      check_val("det_once", 32'(brightness_o), 10);
      wcyc(1000);
      check_val("det_hold", 32'(brightness_o), 10);
      count_led(0, hi);
      check_val("pwm_10", 32'(hi), 10);

      // saturation at the top
      exp_b = 10;
      for (int i = 0; i < 25; i++) begin
         detent_r();
         exp_b = (exp_b + 10 > 255) ? 255 : exp_b + 10;
         check_val("sat_step", 32'(brightness_o), 32'(exp_b));
         if (i == 23) check_val("sat_250", 32'(brightness_o), 250);
      end
      check_val("sat_255", 32'(brightness_o), 255);
      count_led(0, hi);
      check_val("pwm_255", 32'(hi), 255);

      // floor at the bottom
      for (int i = 0; i < 26; i++) begin
         detent_l();
         exp_b = (exp_b < 10) ? 0 : exp_b - 10;
         check_val("floor_step", 32'(brightness_o), 32'(exp_b));
         if (i == 24) check_val("floor_5", 32'(brightness_o), 5);
      end
      check_val("floor_0", 32'(brightness_o), 0);
      count_led(0, hi);
      check_val("pwm_0", 32'(hi), 0);

      // glitch and aborted rotation leave a nonzero value untouched
      detent_r();
      check_val("pre_glitch", 32'(brightness_o), 10);
      a_i = 1'b0; wcyc(50); a_i = 1'b1; wcyc(300);
      check_val("glitch", 32'(brightness_o), 10);
      a_i = 1'b0; wcyc(PH);
      b_i = 1'b0; wcyc(PH);
      b_i = 1'b1; wcyc(PH);
      a_i = 1'b1; wcyc(PH);
      check_val("reversal", 32'(brightness_o), 10);

      // selection wrap; channel 1 gets three detents
      press();
      check_val("sel_1", 32'(sel_o), 1);
      check_val("ch1_init", 32'(brightness_o), 0);
      detent_r(); detent_r(); detent_r();
      check_val("ch1_30", 32'(brightness_o), 30);
      count_led(1, hi);
      check_val("pwm_ch1", 32'(hi), 30);
      count_led(0, hi);
      check_val("pwm_ch0", 32'(hi), 10);
      press();
      check_val("sel_2", 32'(sel_o), 2);
      check_val("ch2_hold", 32'(brightness_o), 0);
      press();
      check_val("sel_3", 32'(sel_o), 3);
      check_val("ch3_hold", 32'(brightness_o), 0);
      press();
      check_val("sel_0", 32'(sel_o), 0);
      check_val("ch0_hold", 32'(brightness_o), 10);

      // button and final detent edge land in the same debounced cycle
      a_i = 1'b0; wcyc(PH);
      b_i = 1'b0; wcyc(PH);
      a_i = 1'b1; wcyc(PH);
      b_i = 1'b1; btn_i = 1'b1; wcyc(PH);
      btn_i = 1'b0; wcyc(PH);
      check_val("simul_sel", 32'(sel_o), 1);
      check_val("simul_ch1", 32'(brightness_o), 30);
      press(); press(); press();
      check_val("simul_sel0", 32'(sel_o), 0);
      check_val("simul_ch0", 32'(brightness_o), 20);

      // reset in the middle of a rotation
      a_i = 1'b0; wcyc(PH);
      b_i = 1'b0; wcyc(PH);
      rst_i = 1'b1; wcyc(3); rst_i = 1'b0;
      @(negedge clk_i);
      check_val("mid_rst_bright", 32'(brightness_o), 0);
      check_val("mid_rst_sel", 32'(sel_o), 0);
      check_val("mid_rst_leds", 32'(leds_o), 0);
      wcyc(PH);
      a_i = 1'b1; wcyc(PH);
      b_i = 1'b1; wcyc(PH);
      check_val("release", 32'(brightness_o), 0);
      detent_r();
      check_val("post_rst_det", 32'(brightness_o), 10);
      press();
      check_val("post_rst_ch1", 32'(brightness_o), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
